// File: rtl/meter_ctrl_pkg.sv
// Shared taxi-meter definitions: trip state encoding and default wheel timeout,
// used by the meter controller and the display/fee blocks.
package meter_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } trip_state_t;

    // 1 s of wheel silence at 50 MHz before a moving trip counts as waiting.
    localparam logic [31:0] WHEEL_TIMEOUT_DEFAULT = 32'd50_000_000;

endpackage

// File: rtl/meter_ctrl_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
// An input that is already high when reset releases never produces a pulse.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic meta;
    logic sync;
    logic sync_d;
    logic started;
    logic armed;

    // armed waits for the input to be seen low once after reset, so a key held
    // through reset must be released and pressed again before it counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta    <= 1'b0;
            sync    <= 1'b0;
            sync_d  <= 1'b0;
            started <= 1'b0;
            armed   <= 1'b0;
            rise    <= 1'b0;
        end else begin
            meta    <= din;
            sync    <= meta;
            sync_d  <= sync;
            started <= 1'b1;
            armed   <= armed | (started & ~meta);
            rise    <= armed & sync & ~sync_d;
        end
    end

endmodule

// File: rtl/meter_ctrl.sv
// Taxi trip controller: sequences IDLE/RUN/WAIT/HOLD from key and wheel edges,
// emits distance pulses, waiting-time enable and fee-clear strobes.
//
// state | meaning
// IDLE  | no trip, display cleared, waiting for start
// RUN   | cab moving, wheel edges produce distance pulses
// WAIT  | no wheel edge for WHEEL_TIMEOUT cycles, waiting time accrues
// HOLD  | trip ended, fare frozen until start or clear
module meter_ctrl
    import meter_ctrl_pkg::*;
#(
    parameter logic [31:0] WHEEL_TIMEOUT = WHEEL_TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_key,
    input  logic       stop_key,
    input  logic       clr_key,
    input  logic       wheel,
    input  logic       max,
    output logic       wait_en,
    output logic       dist_pulse,
    output logic       fee_clr,
    output logic [1:0] state
);

    localparam logic [31:0] CNT_LAST = WHEEL_TIMEOUT - 32'd1;

    logic start_ev;
    logic stop_ev;
    logic clr_ev;
    logic wheel_ev;

    sync_edge u_sync_start (.clk(clk), .rst_n(rst_n), .din(start_key), .rise(start_ev));
    sync_edge u_sync_stop  (.clk(clk), .rst_n(rst_n), .din(stop_key),  .rise(stop_ev));
    sync_edge u_sync_clr   (.clk(clk), .rst_n(rst_n), .din(clr_key),   .rise(clr_ev));
    sync_edge u_sync_wheel (.clk(clk), .rst_n(rst_n), .din(wheel),     .rise(wheel_ev));

    trip_state_t state_q, state_nxt;
    logic [31:0] cnt_q, cnt_nxt;
    logic        wait_en_q, wait_en_nxt;
    logic        dist_q, dist_nxt;
    logic        fee_clr_q, fee_clr_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            wait_en_q <= 1'b0;
            dist_q    <= 1'b0;
            fee_clr_q <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            wait_en_q <= wait_en_nxt;
            dist_q    <= dist_nxt;
            fee_clr_q <= fee_clr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = '0;
        dist_nxt    = 1'b0;
        fee_clr_nxt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ev) begin
                    state_nxt   = ST_RUN;
                    fee_clr_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop_ev) begin
                    state_nxt = ST_HOLD;
                end else if (wheel_ev) begin
                    dist_nxt = !max;
                end else if (cnt_q == CNT_LAST) begin
                    state_nxt = ST_WAIT;
                end else begin
                    cnt_nxt = cnt_q + 32'd1;
                end
            end
            ST_WAIT: begin
                if (stop_ev) begin
                    state_nxt = ST_HOLD;
                end else if (wheel_ev) begin
                    state_nxt = ST_RUN;
                    dist_nxt  = !max;
                end
            end
            ST_HOLD: begin
                if (start_ev) begin
                    state_nxt   = ST_RUN;
                    fee_clr_nxt = 1'b1;
                end else if (clr_ev) begin
                    state_nxt   = ST_IDLE;
                    fee_clr_nxt = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // A clear followed at once by a start: the accumulator was cleared the
        // cycle before, so the second strobe is redundant and is dropped.
        if (fee_clr_q) fee_clr_nxt = 1'b0;
        wait_en_nxt = (state_nxt == ST_WAIT) && !max;
    end

    assign state      = state_q;
    assign wait_en    = wait_en_q;
    assign dist_pulse = dist_q;
    assign fee_clr    = fee_clr_q;

endmodule

// File: doc/meter_ctrl.md
METER_CTRL -- requirements
Module: meter_ctrl

Interface
REQ-001 Parameter WHEEL_TIMEOUT, default 32'd50_000_000: clk cycles without a wheel edge before RUN falls to WAIT.
REQ-002 clk  input  1  system clock, 50 MHz.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start_key  input  1  asynchronous, debounced level; rising edge = start trip.
REQ-005 stop_key  input  1  asynchronous, debounced level; rising edge = end trip.
REQ-006 clr_key  input  1  asynchronous, debounced level; rising edge = clear display, return to idle.
REQ-007 wheel  input  1  asynchronous wheel-sensor pulse; each rising edge = one distance unit.
REQ-008 max  input  1  fare-saturated flag from the fee accumulator, synchronous to clk.
REQ-009 wait_en  output  1  enable for the minute divider; counts waiting time.
REQ-010 dist_pulse  output  1  one-cycle pulse per qualified wheel edge.
REQ-011 fee_clr  output  1  one-cycle clear pulse to the fee accumulator and divider.
REQ-012 state  output  2  current trip state: IDLE=0, RUN=1, WAIT=2, HOLD=3.

Function
REQ-013 Every asynchronous input passes a 2-flop synchronizer plus a rising-edge detector; an input first sampled high at edge N produces its edge event at edge N+2 and a state/output change at edge N+3.
REQ-014 IDLE: start edge -> RUN with fee_clr high for exactly one cycle; all other events ignored.
REQ-015 RUN: wheel edge -> dist_pulse for one cycle (unless max) and timeout counter cleared to 0.
REQ-016 RUN: no wheel edge -> counter increments each cycle; at counter == WHEEL_TIMEOUT-1 -> WAIT, counter cleared.
REQ-017 WAIT: wheel edge -> RUN, counter cleared, dist_pulse issued for that edge (unless max).
REQ-018 RUN or WAIT: stop edge -> HOLD; stop takes priority over a simultaneous wheel edge or timeout.
REQ-019 HOLD: start edge -> RUN with one-cycle fee_clr; clr edge -> IDLE with one-cycle fee_clr; start wins if both occur in the same cycle.
REQ-020 IDLE: simultaneous start and stop edges -> RUN; stop is ignored.
REQ-021 wait_en = (state == WAIT) && !max, registered; it changes on the cycle the state changes.
REQ-022 max high -> dist_pulse and wait_en forced 0; state transitions and the timeout counter are unaffected.
REQ-023 Timeout counter is 32 bits unsigned; it never exceeds WHEEL_TIMEOUT-1, holds 0 outside RUN, and does not wrap.
REQ-024 fee_clr never asserts for two consecutive cycles; it is never asserted together with dist_pulse.
REQ-025 start_key, clr_key, and stop_key held high produce exactly one edge event each; re-triggering requires a low-then-high input.

Reset
REQ-026 rst_n low -> state = IDLE, wait_en = 0, dist_pulse = 0, fee_clr = 0, counter = 0, synchronizer and edge registers = 0, immediately and asynchronously.
REQ-027 Reset asserted mid-trip discards the trip; after release the block is in IDLE and requires a new start edge.
REQ-028 An input already high at reset release does not generate an edge event.

Structure
REQ-029 State encodings and the default WHEEL_TIMEOUT value live in the shared taxi definitions header, used by meter_ctrl and the display/fee blocks.
REQ-030 One sub-module, sync_edge (2-flop synchronizer plus registered rising-edge pulse), is instantiated four times; the FSM and counter are in meter_ctrl.

Verification (WHEEL_TIMEOUT overridden to 8)
REQ-031 Reset, then a start pulse -> fee_clr one cycle 3 cycles later, state = 1, wait_en = 0.
REQ-032 In RUN, no wheel for 8 cycles -> state = 2 and wait_en = 1; a wheel edge then -> state = 1, one dist_pulse, wait_en = 0.
REQ-033 In RUN, wheel edges every 5 cycles for 100 cycles -> state stays 1, dist_pulse count equals wheel edge count.
REQ-034 In WAIT, max = 1 -> wait_en = 0, state stays 2; a wheel edge -> state = 1 with no dist_pulse.
REQ-035 In WAIT, stop and wheel in the same cycle -> state = 3; then start and clr together -> state = 1 with a single fee_clr.
REQ-036 rst_n pulsed low in RUN with start_key held high -> state = 0 and remains 0 until start_key toggles low then high.
